// File: rtl/wb_cnn_slave.sv
// wb_cnn_slave: Wishbone pipelined responder fronting the CNN core.
//
// Holds the 8x8 input image (IMG_WORDS x 32-bit, 4 pixels per word), the
// CTRL/STATUS register and the RES_WORDS x 32-bit result buffer. It turns host
// bus cycles into core start pulses and serves the core-side memory ports.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   i_wb_cyc/stb/we     Wishbone cycle, strobe, write-enable
//   i_wb_sel[3:0]       byte-lane enables (image writes)
//   i_wb_addr[31:0]     byte address
//   i_wb_data[31:0]     write data
//   o_wb_data[31:0]     read data, valid with o_wb_ack
//   o_wb_ack            one-cycle acknowledge, registered
//   o_wb_stall          combinational stall (core owns image/result region)
//   o_start             one-cycle core start pulse
//   i_done              one-cycle core completion pulse
//   i_px_addr[5:0]      core pixel read address
//   o_px_data[7:0]      pixel, one cycle after i_px_addr
//   i_res_we/addr/data  core result write port
//   o_irq               only with WB_CNN_IRQ_EN: done & irq_en, registered
//
// Build option: define WB_CNN_IRQ_EN to add o_irq and the CTRL irq_en bit.
module wb_cnn_slave #(
    parameter int IMG_WORDS = 16,
    parameter int RES_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_start,
    input  logic        i_done,
    input  logic [5:0]  i_px_addr,
    output logic [7:0]  o_px_data,
    input  logic        i_res_we,
    input  logic [3:0]  i_res_addr,
    input  logic [31:0] i_res_data
`ifdef WB_CNN_IRQ_EN
    ,
    output logic        o_irq
`endif
);
    localparam int IW = $clog2(IMG_WORDS);
    localparam int RW = $clog2(RES_WORDS);
    localparam logic [6:0] IMG_LIM = 7'(IMG_WORDS);
    localparam logic [6:0] RES_LIM = 7'(RES_WORDS);

    logic [31:0] img_mem [IMG_WORDS];
    logic [31:0] res_mem [RES_WORDS];

    logic [3:0]  region;
    logic [5:0]  widx, res_off;
    logic [IW-1:0] img_idx;
    logic [RW-1:0] res_idx;
    logic        is_img, is_ctrl, is_res;
    logic        accept, wr, rd, ctrl_wr, start_req;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, start_q, start_d;
    logic        ack_q;
    logic [31:0] data_q, rdata_d, status;
    logic [7:0]  px_q;

    assign region  = i_wb_addr[31:28];
    assign widx    = i_wb_addr[7:2];
    assign res_off = widx - 6'd1;
    assign img_idx = widx[IW-1:0];
    assign res_idx = res_off[RW-1:0];

    assign is_img  = (region == 4'h0) && ({1'b0, widx} < IMG_LIM);
    assign is_ctrl = (region == 4'h4) && (widx == 6'd0);
    assign is_res  = (region == 4'h4) && (widx != 6'd0) && ({1'b0, widx} <= RES_LIM);

    // Core owns the image and result ports while busy; CTRL stays reachable.
    assign o_wb_stall = busy_q & (is_img | is_res);
    assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign wr         = accept & i_wb_we;
    assign rd         = accept & ~i_wb_we;
    assign ctrl_wr    = wr & is_ctrl;
    assign start_req  = ctrl_wr & i_wb_data[0];

`ifdef WB_CNN_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d = ctrl_wr ? i_wb_data[3] : irq_en_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end
    assign o_irq = irq_q;
`else
    logic irq_en_q;
    assign irq_en_q = 1'b0;
`endif

    assign status = {28'b0, irq_en_q, err_q, done_q, busy_q};

    // Completion is applied first so that a start landing with i_done while
    // busy still counts as a start-while-busy error.
    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        start_d = 1'b0;
        if (i_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end
        if (ctrl_wr && i_wb_data[2])
            err_d = 1'b0;
        if (start_req) begin
            if (busy_q) begin
                err_d = 1'b1;
            end else begin
                busy_d  = 1'b1;
                done_d  = 1'b0;
                start_d = 1'b1;
            end
        end
    end

    assign rdata_d = !rd    ? 32'h0 :
                     is_img  ? img_mem[img_idx] :
                     is_ctrl ? status :
                     is_res  ? res_mem[res_idx] : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= 32'h0;
            px_q    <= 8'h0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
            ack_q   <= accept;
            data_q  <= rdata_d;
            px_q    <= img_mem[i_px_addr[IW+1:2]][{i_px_addr[1:0], 3'b000} +: 8];
        end
    end

    // Writes land at acceptance, so a later cyc drop only loses the ack.
    always_ff @(posedge clk) begin
        if (wr && is_img)
            for (int b = 0; b < 4; b++)
                if (i_wb_sel[b])
                    img_mem[img_idx][8*b +: 8] <= i_wb_data[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RES_WORDS; i++)
                res_mem[i] <= 32'h0;
        end else if (i_res_we) begin
            res_mem[i_res_addr[RW-1:0]] <= i_res_data;
        end
    end

    assign o_wb_ack  = ack_q & i_wb_cyc;
    assign o_wb_data = data_q;
    assign o_start   = start_q;
    assign o_px_data = px_q;

    logic unused_bits;
    assign unused_bits = ^{i_wb_addr[27:8], i_wb_addr[1:0], res_off[5:RW]};
endmodule

// File: tb/tb_wb_cnn_slave.sv
// tb_wb_cnn_slave: scoreboard bench for the Wishbone CNN responder.
module tb_wb_cnn_slave;
    logic        clk, rst;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_addr, i_wb_data, o_wb_data;
    logic        o_wb_ack, o_wb_stall, o_start, i_done;
    logic [5:0]  i_px_addr;
    logic [7:0]  o_px_data;
    logic        i_res_we;
    logic [3:0]  i_res_addr;
    logic [31:0] i_res_data;
`ifdef WB_CNN_IRQ_EN
    logic        o_irq;
`endif

    wb_cnn_slave dut (
        .clk(clk), .rst(rst),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_data(o_wb_data), .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall),
        .o_start(o_start), .i_done(i_done),
`ifdef WB_CNN_IRQ_EN
        .o_irq(o_irq),
`endif
        .i_px_addr(i_px_addr), .o_px_data(o_px_data),
        .i_res_we(i_res_we), .i_res_addr(i_res_addr), .i_res_data(i_res_data)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        rd;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0, start_cnt = 0, stall_cnt = 0, ack_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation; reads also compare data.
    always @(negedge clk) begin
        exp_t e;
        if (o_start) start_cnt++;
        if (o_wb_ack) begin
            ack_no++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected #%0d: got ack with data %h expected no ack", ack_no, o_wb_data);
            end else begin
                e = q.pop_front();
                if (e.rd && o_wb_data !== e.d) begin
                    errors++;
                    $display("FAIL bus_read #%0d: got %h expected %h", ack_no, o_wb_data, e.d);
                end
            end
        end
    end

    task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] e);
        int n = 0;
        logic st;
        @(posedge clk);
        #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
        i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
        do begin
            @(negedge clk);
            st = o_wb_stall;
            @(posedge clk);
            n++;
        end while (st && n < 60);
        stall_cnt = n - 1;
        if (st) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr %h: got stall after %0d cycles expected accept", a, n);
        end else begin
            q.push_back('{d: e, rd: !we});
        end
        #1;
        i_wb_stb = 1'b0; i_wb_we = 1'b0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        wb(1'b1, a, d, 4'hF, 32'h0);
    endtask

    task automatic rd32(input logic [31:0] a, input logic [31:0] e);
        wb(1'b0, a, 32'h0, 4'hF, e);
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 i_done = 1'b1;
        @(posedge clk);
        #1 i_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_sel = 0;
        i_wb_addr = 0; i_wb_data = 0; i_done = 0; i_px_addr = 0;
        i_res_we = 0; i_res_addr = 0; i_res_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'b0, o_wb_ack}, 32'h0);
        chk("rst_data", o_wb_data, 32'h0);
        chk("rst_stall", {31'b0, o_wb_stall}, 32'h0);
        chk("rst_start", {31'b0, o_start}, 32'h0);
        chk("rst_px", {24'b0, o_px_data}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        rd32(32'h4000_0000, 32'h0);
        rd32(32'h4000_0004, 32'h0);

        for (int k = 0; k < 16; k++)
            wr32(32'(4 * k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
        for (int k = 0; k < 16; k++)
            rd32(32'(4 * k), {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});

        @(posedge clk);
        #1 i_px_addr = 6'd37;
        @(posedge clk);
        @(negedge clk);
        chk("px_37", {24'b0, o_px_data}, 32'h25);

        wr32(32'h4000_0000, 32'h1);
        repeat (2) @(posedge clk);
        chk("start_pulses_1", start_cnt, 1);
        rd32(32'h4000_0000, 32'h1);

        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 i_res_we = 1'b1; i_res_addr = 4'(i); i_res_data = 32'hA0 + 32'(i);
        end
        @(posedge clk);
        #1 i_res_we = 1'b0;

        wr32(32'h4000_0000, 32'h1);
        repeat (2) @(posedge clk);
        chk("start_while_busy_no_pulse", start_cnt, 1);
        rd32(32'h4000_0000, 32'h5);
        wr32(32'h4000_0000, 32'h4);
        rd32(32'h4000_0000, 32'h1);

        fork
            rd32(32'h0000_0010, 32'h13121110);
            begin
                repeat (6) @(posedge clk);
                #1 i_done = 1'b1;
                @(posedge clk);
                #1 i_done = 1'b0;
            end
        join
        chk("img_read_stalled_while_busy", {31'b0, stall_cnt >= 5}, 32'h1);
        rd32(32'h4000_0000, 32'h2);

        for (int i = 0; i < 16; i++)
            rd32(32'h4000_0004 + 32'(4 * i), 32'hA0 + 32'(i));

        wr32(32'h2000_0000, 32'hDEADBEEF);
        rd32(32'h2000_0000, 32'h0);
        wb(1'b1, 32'h0, 32'hFFFF_FFFF, 4'b0010, 32'h0);
        rd32(32'h0, 32'h0302FF00);
        wr32(32'h4000_0004, 32'h12345);
        rd32(32'h4000_0004, 32'hA0);

        // Write with cyc dropped before the ack: no ack, data still stored.
        @(posedge clk);
        #1 i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_sel = 4'hF;
        i_wb_addr = 32'h4; i_wb_data = 32'h11223344;
        @(posedge clk);
        #1 i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
        @(negedge clk);
        chk("ack_suppressed_cyc_low", {31'b0, o_wb_ack}, 32'h0);
        rd32(32'h4, 32'h11223344);

        // Reset while busy with an ack pending.
        wr32(32'h4000_0000, 32'h1);
        repeat (2) @(posedge clk);
        chk("start_pulses_2", start_cnt, 2);
        @(posedge clk);
        #1 i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h4000_0000;
        @(posedge clk);
        #1 rst = 1'b0; i_wb_stb = 0;
        @(negedge clk);
        chk("mid_reset_ack", {31'b0, o_wb_ack}, 32'h0);
        chk("mid_reset_stall", {31'b0, o_wb_stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        rd32(32'h4000_0000, 32'h0);
        rd32(32'h8, 32'h0B0A0908);

`ifdef WB_CNN_IRQ_EN
        wr32(32'h4000_0000, 32'h8);
        rd32(32'h4000_0000, 32'h8);
        wr32(32'h4000_0000, 32'h9);
        pulse_done();
        @(negedge clk);
        chk("irq_high", {31'b0, o_irq}, 32'h1);
        rd32(32'h4000_0000, 32'hA);
        @(negedge clk);
        chk("irq_held", {31'b0, o_irq}, 32'h1);
        wr32(32'h4000_0000, 32'h9);
        @(negedge clk);
        chk("irq_cleared_by_start", {31'b0, o_irq}, 32'h0);
`else
        wr32(32'h4000_0000, 32'h8);
        rd32(32'h4000_0000, 32'h0);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_cnn_slave.md
# wb_cnn_slave

Wishbone pipelined responder that fronts the CNN core. It holds the 8x8 input image, the control/status register, and the 16-word output feature map, and it decodes host bus cycles into start pulses and core-side memory ports. It sits behind the Wishbone interconnect as the CNN target, so a host can write pixels, start the core, poll status and read results with ordinary single-beat bus transactions.

## Interface
- IMG_WORDS, 16: image RAM depth in 32-bit words, 4 pixels per word, pixel `i` in byte lane `i%4`.
- RES_WORDS, 16: result buffer depth in 32-bit words.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone cycle, strobe and write-enable.
- i_wb_sel  in  4  byte-lane enables.
- i_wb_addr  in  32  byte address.
- i_wb_data  in  32  write data.
- o_wb_data  out  32  read data, valid with o_wb_ack.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_wb_stall  out  1  request not accepted this cycle.
- o_start  out  1  one-cycle core start pulse.
- i_done  in  1  one-cycle core completion pulse.
- i_px_addr  in  6  core pixel read address.
- o_px_data  out  8  pixel, registered, one cycle after i_px_addr.
- i_res_we  in  1  core result write strobe.
- i_res_addr  in  4  result word index.
- i_res_data  in  32  result word.

## Operation
- Request accepted when i_wb_cyc & i_wb_stb & !o_wb_stall.
- Address map, decoded on i_wb_addr[31:28] and word index i_wb_addr[7:2]:
  - 0x0000_0000–0x0000_003C: image RAM, read/write, writes honour i_wb_sel.
  - 0x4000_0000: CTRL/STATUS. Reads return {28'b0, irq_en, err, done, busy}. Writes: bit0=1 starts the core, bit2=1 clears err (write-1-to-clear), bit3 loads irq_en.
  - 0x4000_0004–0x4000_0040: result word `(addr-4)>>2`, read-only. Writes are acked and ignored.
  - Any other address: acked, read data 0, writes ignored.
- Start with busy=0: o_start pulses for one cycle, busy←1, done←0.
- Start with busy=1: no pulse; err←1.
- i_done while busy: busy←0, done←1. i_done while idle is ignored.
- While busy, the core owns the image RAM port and the result write port. Host image or result accesses stall; CTRL and unmapped accesses are still served.
- i_res_we writes the result buffer on any cycle. Host result reads are never concurrent with it, because they stall while busy.

## Timing
- Reset values: o_wb_ack=0, o_wb_data=0, o_wb_stall=0, o_start=0, o_px_data=0, busy=done=err=irq_en=0, result buffer all 0. Image RAM is not reset.
- Latency: o_wb_ack and o_wb_data are registered one cycle after acceptance. Back-to-back accepts give one ack per cycle.
- o_wb_stall is combinational from busy and the current address region. It is held while busy=1 and the request targets the image or result region.
- If i_wb_cyc is low in the cycle an ack would issue, the ack is suppressed, and a write accepted earlier still completes.
- A CTRL start write accepted in cycle N gives o_start high in N+1 and busy=1 visible on a read accepted in N+1.
- If i_done and a start write land in the same cycle while busy: done←1 and busy←0 take effect, the start is treated as arriving while busy, and err←1.
- Reset asserted mid-operation clears busy, done, err and all pending acks immediately. The core must also be reset.

## Configuration
- WB_CNN_IRQ_EN defined: adds output o_irq (1 bit, reset 0), registered, equal to done & irq_en.
- WB_CNN_IRQ_EN undefined: no o_irq port, CTRL bit3 reads 0, and writes to bit3 are ignored.

## Test plan
- Write words 0x03020100 … 0x3F3E3D3C to 0x0000_0000–0x0000_003C, then read them back. Each reads exactly as written, one ack per access. Drive i_px_addr=37 and expect o_px_data=0x25 one cycle later.
- Write 0x1 to 0x4000_0000. Expect a single o_start pulse and STATUS=0x1. Attempt a 0x0000_0010 read: it stalls until i_done, then acks. STATUS then reads 0x2.
- Write start while busy. Expect no o_start and STATUS=0x5. Then write 0x4: STATUS=0x1.
- While busy, core writes i_res_addr=0..15 with data 0xA0+i. After i_done, reads of 0x4000_0004+4i return 0xA0+i.
- Write to 0x2000_0000: acked and ignored. Read it back: returns 0. Write image word 0 with sel=0010 and data 0xFFFFFFFF: only byte 1 changes.
- Assert reset while busy. Expect STATUS=0 and o_wb_ack=0. With WB_CNN_IRQ_EN, set irq_en, start, pulse i_done: o_irq=1 until the next start.
